alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU of piRISC; consumes the 4-bit aluop produced by alu_controller plus two operands.
//  Simple ops complete in 1 cycle. Shifts are iterative, 1 bit per cycle.
//  Valid/ready handshakes on the input and output sides; the result is held until it is accepted.
// PARAMETERS
//  WIDTH    32  operand/result width
//  AWIDTH   4   aluop width
//  SHWIDTH  5   shift-amount width (log2 WIDTH); shamt = operand_b[SHWIDTH-1:0]
// PORTS
//  clk        in   1       clock, all state updates on the rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operands and aluop are valid
//  in_ready   out  1       unit can accept an operation this cycle
//  aluop      in   AWIDTH  ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9; 10-15 execute as ADD
//  operand_a  in   WIDTH   rs1 value
//  operand_b  in   WIDTH   rs2 value or immediate
//  out_valid  out  1       result/zero are valid
//  out_ready  in   1       consumer accepts the result
//  result     out  WIDTH   registered result
//  zero       out  1       registered (result == 0)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge): state=IDLE; result=0, zero=0, out_valid=0, shift counter=0.
//   Reset wins over every other event, including reset in the middle of a shift; the in-flight op is dropped.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back issue in the same edge the result is taken.
//  Accept = in_valid & in_ready at an edge. aluop and operands are captured only on accept.
//  FSM states: IDLE, SHIFT, DONE.
//   Accept of a non-shift op, or of a shift with shamt=0 -> DONE.
//    result/zero are written at the accept edge; out_valid=1 from the next cycle (latency 1).
//   Accept of a shift with shamt=s>0 -> SHIFT.
//    At the accept edge: work=operand_a, cnt=s.
//    Each edge in SHIFT: work shifted by 1, cnt--.
//    SLL: fill 0 on the left shift. SRL: fill 0 on the right shift. SRA: fill with work[WIDTH-1].
//    The edge with cnt==1 writes result=shifted value and moves to DONE.
//    out_valid=1 after s edges total (latency s; max 31).
//   DONE: out_valid=1; result and zero are held stable while out_ready=0.
//    out_ready=1 & new accept -> the new op starts (DONE or SHIFT as above).
//    out_ready=1 & no accept -> IDLE, out_valid=0.
//  Arithmetic: all ops are modulo 2^WIDTH; no carry or overflow outputs.
//   SUB = a + ~b + 1.
//   SLT  = {0.., $signed(a) < $signed(b)}.
//   SLTU = {0.., a < b} (unsigned).
//   Shift amount uses only operand_b[SHWIDTH-1:0]; upper bits are ignored.
//  Inputs are ignored while in_ready=0. in_valid may drop without an accept (no side effects).
//  busy=1 in SHIFT and DONE.
// TESTING
//  T1 Reset: rst held 2 cycles -> out_valid=0, result=0, zero=0, in_ready=1, busy=0.
//  T2 ADD 0x7FFFFFFF+1 -> result=0x80000000 one cycle later.
//     SUB 5-5 -> result=0, zero=1.
//     SLT 0xFFFFFFFF vs 1 -> 1. SLTU with the same operands -> 0.
//  T3 SRA a=0x80000000, b=0x00000024 (shamt=4) -> out_valid after exactly 4 cycles, result=0xF8000000.
//     SLL with shamt=0 -> result=a after 1 cycle.
//  T4 Backpressure: XOR 0xF0F0F0F0^0xFFFF0000 with out_ready=0 for 5 cycles
//     -> result=0x0F0FF0F0 held stable, in_ready=0.
//     Then out_ready=1 together with in_valid for OR -> OR is accepted the same edge; its result follows 1 cycle later.
//  T5 Reset mid-shift: SRL with shamt=20, rst asserted at cycle 7 -> IDLE next cycle, out_valid never asserts for that op.
//  T6 Back-to-back random stream of 1000 ops with random out_ready vs a reference model
//     -> every result matches, in order, with no drops or duplicates.

Source files
------------

// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/aluop issue handshake and result return handshake
// for the piRISC execute-stage ALU.
interface alu_exec_if #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] aluop;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              zero;

  modport master (
    output in_valid, aluop, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, aluop, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: piRISC execute-stage ALU; single-cycle logic ops and
// iterative 1-bit-per-cycle shifts behind valid/ready handshakes.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int AWIDTH  = 4,
  parameter int SHWIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  io,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [AWIDTH-1:0] OP_SUB  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] OP_XOR  = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] OP_OR   = AWIDTH'(3);
  localparam logic [AWIDTH-1:0] OP_AND  = AWIDTH'(4);
  localparam logic [AWIDTH-1:0] OP_SLL  = AWIDTH'(5);
  localparam logic [AWIDTH-1:0] OP_SRL  = AWIDTH'(6);
  localparam logic [AWIDTH-1:0] OP_SRA  = AWIDTH'(7);
  localparam logic [AWIDTH-1:0] OP_SLT  = AWIDTH'(8);
  localparam logic [AWIDTH-1:0] OP_SLTU = AWIDTH'(9);

  localparam logic [SHWIDTH-1:0] CNT_ONE = SHWIDTH'(1);

  state_e             state_q, state_d;
  logic [AWIDTH-1:0]  op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHWIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic [SHWIDTH-1:0] shamt;
  logic               accept;
  logic               is_shift;
  logic               start_shift;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shift_val;

  assign shamt    = io.operand_b[SHWIDTH-1:0];
  assign accept   = io.in_valid & io.in_ready;
  assign is_shift = (io.aluop == OP_SLL) |
                    (io.aluop == OP_SRL) |
                    (io.aluop == OP_SRA);
  assign start_shift = is_shift & (shamt != '0);

  // Shifts only reach this path with shamt=0, where the result is operand_a.
  always_comb begin
    alu_res = io.operand_a + io.operand_b;
    case (io.aluop)
      OP_SUB:  alu_res = io.operand_a + ~io.operand_b + WIDTH'(1);
      OP_XOR:  alu_res = io.operand_a ^ io.operand_b;
      OP_OR:   alu_res = io.operand_a | io.operand_b;
      OP_AND:  alu_res = io.operand_a & io.operand_b;
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_res = io.operand_a;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                 $signed(io.operand_a) < $signed(io.operand_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}},
                 io.operand_a < io.operand_b};
      default: alu_res = io.operand_a + io.operand_b;
    endcase
  end

  always_comb begin
    shift_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    unique case (1'b1)
      op_q == OP_SLL: shift_val = {work_q[WIDTH-2:0], 1'b0};
      op_q == OP_SRL: shift_val = {1'b0, work_q[WIDTH-1:1]};
      default:        shift_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = start_shift ? SHIFT : DONE;
    end else begin
      unique case (state_q)
        SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
        DONE:    if (io.out_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    io.in_ready  = (state_q == IDLE) |
                   ((state_q == DONE) & io.out_ready);
    io.out_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
  end

  always_comb begin
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      op_d = io.aluop;
      if (start_shift) begin
        work_d = io.operand_a;
        cnt_d  = shamt;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
      end
    end else if (state_q == SHIFT) begin
      work_d = shift_val;
      cnt_d  = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        result_d = shift_val;
        zero_d   = (shift_val == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign io.result = result_q;
  assign io.zero   = zero_q;

endmodule
